// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_pkg;

  localparam int SAR_NBITS         = 8;
  localparam int SAR_SAMPLE_CYCLES = 2;

  // Width of a down-counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(SAR_NBITS);

  // state  | meaning
  // IDLE   | waiting for a start edge, arrays released
  // SAMPLE | sampling switch closed, s_clk high
  // CMP    | comparator strobe for the current trial bit
  // DEC    | decision cycle; cmp_out captured at its closing edge
  // DONE   | code valid, eoc high, waiting for the next start edge
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CMP    = 3'd2,
    DEC    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sar_cdac_decode.sv
// Combinational mapping from SAR trial code to the differential CDAC switch controls.
// Index 0 is the dummy unit cap; index k+1 follows sar[k].
module sar_cdac_decode
  import sar_pkg::*;
#(
  parameter int NBITS = SAR_NBITS
) (
  input  state_t           state,
  input  logic [NBITS-1:0] sar,
  output logic [NBITS:0]   sca1_top,
  output logic [NBITS:0]   sca1_btm,
  output logic [NBITS:0]   sca2_top,
  output logic [NBITS:0]   sca2_btm
);

  // Top and btm of one cap are always complementary or both off, so no cap shorts the references.
  always_comb begin
    sca1_top = '0;
    sca1_btm = '0;
    sca2_top = '0;
    sca2_btm = '0;
    if (state == CMP || state == DEC || state == DONE) begin
      sca1_top = {sar, 1'b0};
      sca1_btm = {~sar, 1'b1};
      sca2_top = {~sar, 1'b1};
      sca2_btm = {sar, 1'b0};
    end
  end

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: sampling phase, MSB-first binary search,
// registered Moore outputs and CDAC switch drive.
module sar_logic
  import sar_pkg::*;
#(
  parameter int NBITS         = SAR_NBITS,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnvst,
  input  logic             cmp_out,
  output logic [NBITS-1:0] sar,
  output logic             eoc,
  output logic             cmp_clk,
  output logic             s_clk,
  output logic [NBITS:0]   fine_sca1_top,
  output logic [NBITS:0]   fine_sca1_btm,
  output logic [NBITS:0]   fine_sca2_top,
  output logic [NBITS:0]   fine_sca2_btm,
  output logic             fine_switch_S
);

  localparam int IW = idx_width(NBITS);
  localparam int CW = idx_width(SAMPLE_CYCLES);

  state_t           state, state_nxt;
  logic [NBITS-1:0] sar_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             cnvst_d;
  logic             start;
  logic             eoc_nxt, cmp_clk_nxt, s_clk_nxt, switch_nxt;

  // Start edges are honoured only when no conversion is running.
  assign start = cnvst & ~cnvst_d & ((state == IDLE) | (state == DONE));

  // Next-state, next-code and next-output logic; outputs derive from the next state so they register as Moore outputs.
  always_comb begin
    state_nxt = state;
    sar_nxt   = sar;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SAMPLE;
          sar_nxt   = '0;
          cnt_nxt   = CW'(SAMPLE_CYCLES - 1);
        end
      end
      SAMPLE: begin
        if (cnt == '0) begin
          state_nxt          = CMP;
          sar_nxt            = '0;
          sar_nxt[NBITS-1]   = 1'b1;
          idx_nxt            = IW'(NBITS - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CMP: begin
        state_nxt = DEC;
      end
      DEC: begin
        sar_nxt[idx] = cmp_out;
        if (idx != '0) begin
          sar_nxt[idx - 1'b1] = 1'b1;
          idx_nxt             = idx - 1'b1;
          state_nxt           = CMP;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    eoc_nxt     = (state_nxt == DONE);
    cmp_clk_nxt = (state_nxt == CMP);
    s_clk_nxt   = (state_nxt == SAMPLE);
    switch_nxt  = (state_nxt == SAMPLE);
  end

  // State, code, counters and registered outputs; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sar           <= '0;
      idx           <= '0;
      cnt           <= '0;
      cnvst_d       <= 1'b0;
      eoc           <= 1'b0;
      cmp_clk       <= 1'b0;
      s_clk         <= 1'b0;
      fine_switch_S <= 1'b0;
    end else begin
      state         <= state_nxt;
      sar           <= sar_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      cnvst_d       <= cnvst;
      eoc           <= eoc_nxt;
      cmp_clk       <= cmp_clk_nxt;
      s_clk         <= s_clk_nxt;
      fine_switch_S <= switch_nxt;
    end
  end

  sar_cdac_decode #(
    .NBITS (NBITS)
  ) u_cdac_decode (
    .state    (state),
    .sar      (sar),
    .sca1_top (fine_sca1_top),
    .sca1_btm (fine_sca1_btm),
    .sca2_top (fine_sca2_top),
    .sca2_btm (fine_sca2_btm)
  );

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic: expected codes queued at each start edge,
// popped when eoc is due; every cycle of a conversion is checked against a timing model.
module tb_sar_logic;
  import sar_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnvst;
  logic       cmp_out;
  logic [7:0] sar;
  logic       eoc, cmp_clk, s_clk, fine_switch_S;
  logic [8:0] fine_sca1_top, fine_sca1_btm, fine_sca2_top, fine_sca2_btm;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];

  sar_logic dut (
    .clk           (clk),
    .rst           (rst),
    .cnvst         (cnvst),
    .cmp_out       (cmp_out),
    .sar           (sar),
    .eoc           (eoc),
    .cmp_clk       (cmp_clk),
    .s_clk         (s_clk),
    .fine_sca1_top (fine_sca1_top),
    .fine_sca1_btm (fine_sca1_btm),
    .fine_sca2_top (fine_sca2_top),
    .fine_sca2_btm (fine_sca2_btm),
    .fine_switch_S (fine_switch_S)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {sca1_top, sca1_btm, sca2_top, sca2_btm} for a given code.
  function automatic logic [35:0] exp_bus(input logic act, input logic [7:0] s);
    if (!act) return '0;
    return {s, 1'b0, ~s, 1'b1, ~s, 1'b1, s, 1'b0};
  endfunction

  // Trial code presented during bit pair j (bit 7-j under test).
  function automatic logic [7:0] trial(input logic [7:0] target, input int j);
    logic [7:0] r;
    r = '0;
    for (int b = 7; b > 7 - j; b--) r[b] = target[b];
    r[7 - j] = 1'b1;
    return r;
  endfunction

  // ctl_exp = {eoc, cmp_clk, s_clk, fine_switch_S}
  task automatic check_cycle(input string tag, input logic [3:0] ctl_exp,
                             input logic [7:0] sar_exp, input logic act);
    chk({tag, ".ctl"}, {eoc, cmp_clk, s_clk, fine_switch_S}, ctl_exp);
    chk({tag, ".sar"}, sar, sar_exp);
    chk({tag, ".bus"}, {fine_sca1_top, fine_sca1_btm, fine_sca2_top, fine_sca2_btm},
        exp_bus(act, sar_exp));
    chk({tag, ".excl"}, (fine_sca1_top & fine_sca1_btm) | (fine_sca2_top & fine_sca2_btm), 9'h000);
  endtask

  // mode: 0 single-cycle start, 1 cnvst held 10 cycles, 2 extra pulse mid-conversion.
  // abort_at >= 0 asserts rst after that cycle and ends the conversion there.
  task automatic run_conv(input logic [7:0] target, input int mode, input int abort_at);
    logic [3:0] ctl;
    logic [7:0] s;
    logic       act;
    string      tag;
    cnvst = 1'b1;
    sb_q.push_back(target);
    for (int n = 0; n <= 18; n++) begin
      @(posedge clk);
      #1;
      tag = $sformatf("c%02h.n%0d", target, n);
      if (n < 2) begin
        ctl = 4'b0011; s = 8'h00; act = 1'b0;
      end else if (n < 18) begin
        s   = trial(target, (n - 2) / 2);
        ctl = ((n % 2) == 0) ? 4'b0100 : 4'b0000;
        act = 1'b1;
      end else begin
        ctl = 4'b1000; act = 1'b1;
        if (sb_q.size() == 0) begin
          chk({tag, ".sb_pop"}, 64'd0, 64'd1);
          s = 8'h00;
        end else begin
          s = sb_q.pop_front();
        end
      end
      check_cycle(tag, ctl, s, act);

      case (mode)
        1:       cnvst = (n < 9);
        2:       cnvst = (n == 6);
        default: cnvst = 1'b0;
      endcase
      if (n >= 3 && n <= 17 && (n % 2) == 1) cmp_out = target[7 - (n - 3) / 2];
      else                                   cmp_out = 1'($urandom_range(0, 1));

      if (n == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cycle({tag, ".abort"}, 4'b0000, 8'h00, 1'b0);
        chk({tag, ".abort.state"}, dut.state, IDLE);
        rst = 1'b0;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        return;
      end
    end
  endtask

  task automatic hold_done(input logic [7:0] target, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      cmp_out = 1'($urandom_range(0, 1));
      check_cycle($sformatf("c%02h.hold%0d", target, k), 4'b1000, target, 1'b1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    cnvst   = 1'b0;
    cmp_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_cycle($sformatf("rst%0d", k), 4'b0000, 8'h00, 1'b0);
      chk($sformatf("rst%0d.state", k), dut.state, IDLE);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_cycle("post_rst", 4'b0000, 8'h00, 1'b0);
    chk("post_rst.state", dut.state, IDLE);

    run_conv(8'hFF, 0, -1);
    chk("ff.sca1_top", fine_sca1_top, 9'h1FE);
    chk("ff.sca1_btm", fine_sca1_btm, 9'h001);
    hold_done(8'hFF, 2);

    run_conv(8'h00, 0, -1);
    chk("00.sca1_btm", fine_sca1_btm, 9'h1FF);
    chk("00.sca2_btm", fine_sca2_btm, 9'h000);
    hold_done(8'h00, 2);

    run_conv(8'hA5, 0, -1);
    chk("a5.sca1_top", fine_sca1_top[8:1], 8'hA5);
    hold_done(8'hA5, 1);

    run_conv(8'h3C, 1, -1);
    hold_done(8'h3C, 3);

    run_conv(8'h5A, 2, -1);
    hold_done(8'h5A, 1);

    run_conv(8'hC3, 0, 11);
    @(posedge clk);
    #1;
    check_cycle("after_abort", 4'b0000, 8'h00, 1'b0);

    run_conv(8'h96, 0, -1);
    hold_done(8'h96, 2);

    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
